// File: rtl/prim_sequencer.sv
// prim_sequencer: command FIFO plus FSM that splits lines/triangles into edges
// for the shared line-draw engine. Rev 1.0
`timescale 1ns/1ps
`default_nettype none

module prim_sequencer #(
  parameter int XW    = 10,
  parameter int YW    = 9,
  parameter int COLW  = 12,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     Mreset_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_type,
  input  logic [XW-1:0]            cmd_x0,
  input  logic [XW-1:0]            cmd_x1,
  input  logic [XW-1:0]            cmd_x2,
  input  logic [YW-1:0]            cmd_y0,
  input  logic [YW-1:0]            cmd_y1,
  input  logic [YW-1:0]            cmd_y2,
  input  logic [COLW-1:0]          cmd_color,
  output logic                     ln_start,
  output logic [XW-1:0]            ln_x0,
  output logic [XW-1:0]            ln_x1,
  output logic [YW-1:0]            ln_y0,
  output logic [YW-1:0]            ln_y1,
  output logic [COLW-1:0]          ln_color,
  input  logic                     ln_done,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [15:0]              prims_done
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = 1 + 3*XW + 3*YW + COLW;
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_ISSUE  = 3'd2,
    S_WAIT   = 3'd3,
    S_RETIRE = 3'd4
  } state_t;

  state_t          state;
  logic [EW-1:0]   mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            push;
  logic            pop;

  logic            h_type;
  logic [XW-1:0]   h_x0, h_x1, h_x2;
  logic [YW-1:0]   h_y0, h_y1, h_y2;
  logic [COLW-1:0] h_color;

  logic            cur_type;
  logic [XW-1:0]   cur_x0, cur_x1, cur_x2;
  logic [YW-1:0]   cur_y0, cur_y1, cur_y2;
  logic [1:0]      edge_idx;

  assign cmd_ready = (fifo_count != FULL);
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state == S_LOAD);

  assign {h_type, h_x0, h_y0, h_x1, h_y1, h_x2, h_y2, h_color} = mem[rd_ptr];

  // Storage needs no reset: the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= {cmd_type, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_x2, cmd_y2, cmd_color};
  end

  always_ff @(posedge clk or negedge Mreset_n) begin
    if (!Mreset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      fifo_count <= fifo_count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end

  always_ff @(posedge clk or negedge Mreset_n) begin
    if (!Mreset_n) begin
      state      <= S_IDLE;
      edge_idx   <= 2'd0;
      cur_type   <= 1'b0;
      cur_x0     <= '0;
      cur_x1     <= '0;
      cur_x2     <= '0;
      cur_y0     <= '0;
      cur_y1     <= '0;
      cur_y2     <= '0;
      ln_start   <= 1'b0;
      ln_x0      <= '0;
      ln_x1      <= '0;
      ln_y0      <= '0;
      ln_y1      <= '0;
      ln_color   <= '0;
      busy       <= 1'b0;
      prims_done <= 16'd0;
    end else begin
      ln_start <= 1'b0;
      case (state)
        S_IDLE: begin
          busy <= (fifo_count != '0);
          if (fifo_count != '0) state <= S_LOAD;
        end
        // Edge 0 goes out straight from the FIFO head as the pop happens.
        S_LOAD: begin
          cur_type <= h_type;
          cur_x0   <= h_x0;
          cur_x1   <= h_x1;
          cur_x2   <= h_x2;
          cur_y0   <= h_y0;
          cur_y1   <= h_y1;
          cur_y2   <= h_y2;
          edge_idx <= 2'd0;
          ln_x0    <= h_x0;
          ln_y0    <= h_y0;
          ln_x1    <= h_x1;
          ln_y1    <= h_y1;
          ln_color <= h_color;
          ln_start <= 1'b1;
          busy     <= 1'b1;
          state    <= S_ISSUE;
        end
        S_ISSUE: begin
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (ln_done) begin
            if (cur_type && (edge_idx != 2'd2)) begin
              edge_idx <= edge_idx + 2'd1;
              ln_start <= 1'b1;
              state    <= S_ISSUE;
              if (edge_idx == 2'd0) begin
                ln_x0 <= cur_x1;
                ln_y0 <= cur_y1;
                ln_x1 <= cur_x2;
                ln_y1 <= cur_y2;
              end else begin
                ln_x0 <= cur_x2;
                ln_y0 <= cur_y2;
                ln_x1 <= cur_x0;
                ln_y1 <= cur_y0;
              end
            end else begin
              state <= S_RETIRE;
            end
          end
        end
        S_RETIRE: begin
          prims_done <= prims_done + 16'd1;
          busy       <= (fifo_count != '0);
          state      <= (fifo_count != '0) ? S_LOAD : S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_prim_sequencer.sv
// tb_prim_sequencer: scoreboard bench for prim_sequencer with a line-engine model.
// Rev 1.0
`timescale 1ns/1ps
`default_nettype none

module tb_prim_sequencer;

  localparam int XW = 10, YW = 9, COLW = 12, DEPTH = 4, ENG_LAT = 5;

  logic            clk = 1'b0;
  logic            Mreset_n = 1'b0;
  logic            cmd_valid = 1'b0;
  logic            cmd_ready;
  logic            cmd_type = 1'b0;
  logic [XW-1:0]   cmd_x0 = '0, cmd_x1 = '0, cmd_x2 = '0;
  logic [YW-1:0]   cmd_y0 = '0, cmd_y1 = '0, cmd_y2 = '0;
  logic [COLW-1:0] cmd_color = '0;
  logic            ln_start;
  logic [XW-1:0]   ln_x0, ln_x1;
  logic [YW-1:0]   ln_y0, ln_y1;
  logic [COLW-1:0] ln_color;
  logic            ln_done = 1'b0;
  logic            busy;
  logic [2:0]      fifo_count;
  logic [15:0]     prims_done;

  typedef struct packed {
    logic [XW-1:0]   x0;
    logic [YW-1:0]   y0;
    logic [XW-1:0]   x1;
    logic [YW-1:0]   y1;
    logic [COLW-1:0] col;
  } edge_t;

  edge_t exp_q[$];
  int    checks, errors, n_starts, exp_prims;
  int    eng_cnt, done_req, done_served;
  bit    eng_stall, inflight;
  edge_t held;

  prim_sequencer #(.XW(XW), .YW(YW), .COLW(COLW), .DEPTH(DEPTH)) dut (
    .clk(clk), .Mreset_n(Mreset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type),
    .cmd_x0(cmd_x0), .cmd_x1(cmd_x1), .cmd_x2(cmd_x2),
    .cmd_y0(cmd_y0), .cmd_y1(cmd_y1), .cmd_y2(cmd_y2),
    .cmd_color(cmd_color),
    .ln_start(ln_start), .ln_x0(ln_x0), .ln_x1(ln_x1),
    .ln_y0(ln_y0), .ln_y1(ln_y1), .ln_color(ln_color),
    .ln_done(ln_done), .busy(busy), .fifo_count(fifo_count), .prims_done(prims_done)
  );

  always #5 clk = ~clk;

  // Line engine: done ENG_LAT cycles after start unless stalled; extra
  // one-cycle done pulses can be requested by bumping done_req.
  task automatic engine_proc();
    forever begin
      @(posedge clk);
      #2;
      ln_done = 1'b0;
      if (!Mreset_n) begin
        eng_cnt     = 0;
        done_served = done_req;
      end else begin
        if (done_served != done_req) begin
          ln_done     = 1'b1;
          done_served = done_req;
          eng_cnt     = 0;
        end
        if (ln_start) eng_cnt = ENG_LAT;
        else if (eng_cnt > 0 && !eng_stall) begin
          eng_cnt--;
          if (eng_cnt == 0) ln_done = 1'b1;
        end
      end
    end
  endtask

  task automatic monitor_proc();
    edge_t got, want;
    forever begin
      @(negedge clk);
      got = {ln_x0, ln_y0, ln_x1, ln_y1, ln_color};
      if (!Mreset_n) inflight = 1'b0;
      else begin
        if (ln_start) begin
          n_starts++;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL edge_issue: unexpected ln_start got %0d,%0d->%0d,%0d col=%h, none expected",
                     got.x0, got.y0, got.x1, got.y1, got.col);
          end else begin
            want = exp_q.pop_front();
            if (got !== want) begin
              errors++;
              $display("FAIL edge_issue: got %0d,%0d->%0d,%0d col=%h want %0d,%0d->%0d,%0d col=%h",
                       got.x0, got.y0, got.x1, got.y1, got.col,
                       want.x0, want.y0, want.x1, want.y1, want.col);
            end
          end
          held     = got;
          inflight = 1'b1;
        end else if (inflight) begin
          checks++;
          if (got !== held) begin
            errors++;
            $display("FAIL edge_stable: got %h want %h", got, held);
          end
        end
        if (ln_done) inflight = 1'b0;
      end
    end
  endtask

  task automatic push_edge(input int x0, input int y0, input int x1, input int y1, input int col);
    edge_t e;
    e = {XW'(x0), YW'(y0), XW'(x1), YW'(y1), COLW'(col)};
    exp_q.push_back(e);
  endtask

  task automatic send(input bit t, input int x0, input int y0, input int x1, input int y1,
                      input int x2, input int y2, input int col, input bit exp_acc);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_type  = t;
    cmd_x0 = XW'(x0); cmd_y0 = YW'(y0);
    cmd_x1 = XW'(x1); cmd_y1 = YW'(y1);
    cmd_x2 = XW'(x2); cmd_y2 = YW'(y2);
    cmd_color = COLW'(col);
    checks++;
    if (cmd_ready !== exp_acc) begin
      errors++;
      $display("FAIL cmd_ready: got %b want %b", cmd_ready, exp_acc);
    end
    if (exp_acc) begin
      push_edge(x0, y0, x1, y1, col);
      if (t) begin
        push_edge(x1, y1, x2, y2, col);
        push_edge(x2, y2, x0, y0, col);
      end
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int k;
    k = 0;
    while (k < limit && !(busy === 1'b0 && exp_q.size() == 0)) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (!(busy === 1'b0 && exp_q.size() == 0)) begin
      errors++;
      $display("FAIL idle_timeout: busy=%b pending_edges=%0d want busy=0 pending=0", busy, exp_q.size());
    end
  endtask

  task automatic wait_starts(input int target, input int limit);
    int k;
    k = 0;
    while (k < limit && n_starts < target) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (n_starts < target) begin
      errors++;
      $display("FAIL start_timeout: starts=%0d want %0d", n_starts, target);
    end
  endtask

  task automatic check_reset_values(input string tag);
    checks++;
    if (cmd_ready !== 1'b1 || ln_start !== 1'b0 || busy !== 1'b0 || fifo_count !== 3'd0 ||
        prims_done !== 16'd0 || {ln_x0, ln_y0, ln_x1, ln_y1, ln_color} !== '0) begin
      errors++;
      $display("FAIL %s: ready=%b start=%b busy=%b count=%0d prims=%0d ln=%h want 1 0 0 0 0 0",
               tag, cmd_ready, ln_start, busy, fifo_count, prims_done,
               {ln_x0, ln_y0, ln_x1, ln_y1, ln_color});
    end
  endtask

  task automatic test_reset();
    Mreset_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values("reset_held");
    Mreset_n = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_values("reset_released");
  endtask

  task automatic test_line();
    int k;
    send(1'b0, 10, 20, 300, 200, 0, 0, 'hF00, 1'b1);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_rise_early: got %b want 0", busy);
    end
    k = 0;
    while (ln_start !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
      if (k == 2) begin
        checks++;
        if (busy !== 1'b1) begin
          errors++;
          $display("FAIL busy_rise: got %b want 1", busy);
        end
      end
    end
    checks++;
    if (k != 3) begin
      errors++;
      $display("FAIL start_latency: got %0d cycles want 3", k);
    end
    wait_idle(60);
    exp_prims = 1;
    checks++;
    if (prims_done !== 16'(exp_prims) || busy !== 1'b0 || fifo_count !== 3'd0) begin
      errors++;
      $display("FAIL line_retire: prims=%0d busy=%b count=%0d want %0d 0 0",
               prims_done, busy, fifo_count, exp_prims);
    end
  endtask

  task automatic test_triangle();
    int n;
    n = n_starts;
    send(1'b1, 0, 0, 639, 0, 320, 479, 'h0F0, 1'b1);
    wait_starts(n + 2, 60);
    checks++;
    if (prims_done !== 16'(exp_prims)) begin
      errors++;
      $display("FAIL tri_early_retire: prims=%0d want %0d", prims_done, exp_prims);
    end
    wait_idle(80);
    exp_prims++;
    checks++;
    if (prims_done !== 16'(exp_prims) || n_starts != n + 3) begin
      errors++;
      $display("FAIL tri_retire: prims=%0d starts=%0d want %0d %0d",
               prims_done, n_starts - n, exp_prims, 3);
    end
  endtask

  task automatic test_overflow();
    int n;
    eng_stall = 1'b1;
    n = n_starts;
    send(1'b0, 1, 1, 2, 2, 0, 0, 'h001, 1'b1);
    wait_starts(n + 1, 20);
    for (int i = 1; i <= 5; i++)
      send(i == 3, i*7, i*3, 600 - i, 400 - i, i*50, i*40, 'h100 + i*17, i <= 4);
    checks++;
    if (fifo_count !== 3'd4 || cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL fifo_full: count=%0d ready=%b want 4 0", fifo_count, cmd_ready);
    end
    eng_stall = 1'b0;
    wait_idle(400);
    exp_prims += 5;
    checks++;
    if (prims_done !== 16'(exp_prims) || fifo_count !== 3'd0) begin
      errors++;
      $display("FAIL overflow_drain: prims=%0d count=%0d want %0d 0", prims_done, fifo_count, exp_prims);
    end
  endtask

  task automatic test_push_pop();
    int n;
    eng_stall = 1'b1;
    n = n_starts;
    send(1'b0, 11, 12, 13, 14, 0, 0, 'hA01, 1'b1);
    wait_starts(n + 1, 20);
    send(1'b0, 21, 22, 23, 24, 0, 0, 'hA02, 1'b1);
    send(1'b1, 31, 32, 33, 34, 35, 36, 'hA03, 1'b1);
    @(posedge clk);
    #1;
    done_req++;
    @(posedge clk);
    @(posedge clk);
    #1;
    checks++;
    if (fifo_count !== 3'd2) begin
      errors++;
      $display("FAIL pre_load_count: got %0d want 2", fifo_count);
    end
    send(1'b0, 41, 42, 43, 44, 0, 0, 'hA04, 1'b1);
    checks++;
    if (fifo_count !== 3'd2) begin
      errors++;
      $display("FAIL push_pop_count: got %0d want 2", fifo_count);
    end
    eng_stall = 1'b0;
    wait_idle(300);
    exp_prims += 4;
    checks++;
    if (prims_done !== 16'(exp_prims)) begin
      errors++;
      $display("FAIL push_pop_prims: got %0d want %0d", prims_done, exp_prims);
    end
  endtask

  task automatic test_ignore_done();
    done_req++;
    repeat (4) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || prims_done !== 16'(exp_prims) || fifo_count !== 3'd0) begin
      errors++;
      $display("FAIL idle_done: busy=%b prims=%0d count=%0d want 0 %0d 0",
               busy, prims_done, fifo_count, exp_prims);
    end
    eng_stall = 1'b1;
    send(1'b0, 100, 50, 100, 50, 0, 0, 'h5A5, 1'b1);
    @(posedge clk);
    #3;
    done_req++;
    repeat (4) @(negedge clk);
    checks++;
    if (prims_done !== 16'(exp_prims) || busy !== 1'b1) begin
      errors++;
      $display("FAIL issue_done: prims=%0d busy=%b want %0d 1", prims_done, busy, exp_prims);
    end
    eng_stall = 1'b0;
    wait_idle(60);
    exp_prims++;
    checks++;
    if (prims_done !== 16'(exp_prims)) begin
      errors++;
      $display("FAIL ignore_done_retire: got %0d want %0d", prims_done, exp_prims);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    eng_stall = 1'b0;
    n = n_starts;
    send(1'b1, 5, 6, 100, 7, 50, 90, 'hABC, 1'b1);
    send(1'b0, 1, 2, 3, 4, 0, 0, 'h123, 1'b1);
    wait_starts(n + 2, 40);
    @(negedge clk);
    Mreset_n = 1'b0;
    #1;
    check_reset_values("reset_async");
    exp_q.delete();
    exp_prims = 0;
    repeat (2) @(negedge clk);
    Mreset_n = 1'b1;
    repeat (8) @(negedge clk);
    check_reset_values("reset_after_release");
    send(1'b0, 7, 8, 9, 10, 0, 0, 'h321, 1'b1);
    wait_idle(60);
    exp_prims = 1;
    checks++;
    if (prims_done !== 16'(exp_prims)) begin
      errors++;
      $display("FAIL post_reset_prims: got %0d want %0d", prims_done, exp_prims);
    end
  endtask

  initial begin
    checks = 0; errors = 0; n_starts = 0; exp_prims = 0;
    eng_cnt = 0; done_req = 0; done_served = 0;
    eng_stall = 1'b0; inflight = 1'b0; held = '0;
    fork
      engine_proc();
      monitor_proc();
      begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
      end
    join_none
    test_reset();
    test_line();
    test_triangle();
    test_overflow();
    test_push_pop();
    test_ignore_done();
    test_reset_mid();
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
